// File: rtl/serial_wide_adder_pkg.sv
// rtl/serial_wide_adder_pkg.sv - shared constants and FSM encoding for the byte-serial adder
package serial_wide_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte index counter width; a single-byte adder still needs one bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/ripple_adder8.sv
// rtl/ripple_adder8.sv - 8-bit ripple-carry adder, the sole arithmetic element
module ripple_adder8
  import serial_wide_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[BYTE_W];

endmodule

// File: rtl/serial_wide_adder.sv
// rtl/serial_wide_adder.sv - byte-serial multi-precision add/subtract around one ripple_adder8
module serial_wide_adder
  import serial_wide_adder_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W     = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         cout_out,
  output logic         ovf_out
);

  localparam int IDXW = idx_width(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  state_t state, state_nxt;

  logic [NBYTES-1:0][BYTE_W-1:0] a_r, b_r, work, work_nxt;
  logic [IDXW-1:0]               idx;
  logic                          carry;
  logic [BYTE_W-1:0]             add_sum;
  logic                          add_cout;

  ripple_adder8 u_adder (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (idx == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Current byte merged into the collected result; on the last byte this is the full answer.
  always_comb begin
    work_nxt      = work;
    work_nxt[idx] = add_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded.
            a_r   <= a_in;
            b_r   <= sub ? ~b_in : b_in;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          work  <= work_nxt;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            sum_out  <= work_nxt;
            cout_out <= add_cout;
            ovf_out  <= (a_r[NBYTES-1][BYTE_W-1] == b_r[NBYTES-1][BYTE_W-1]) &&
                        (add_sum[BYTE_W-1] != a_r[NBYTES-1][BYTE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
